// File: rtl/hls_call_pkg.sv
// Shared types and sizing helpers for the HLS call/return initiator.
package hls_call_pkg;

  localparam int DEF_A_W = 64;
  localparam int DEF_N_W = 32;
  localparam int DEF_R_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    CALL = 1'b1
  } issue_state_e;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/hls_call_result_fifo.sv
// Result FIFO with a registered head: storage array plus an output register.
// A push into an empty FIFO lands directly in the output register one cycle later.
module hls_call_result_fifo
  import hls_call_pkg::*;
#(
  parameter int R_W   = DEF_R_W,
  parameter int DEPTH = 4
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           push,
  input  logic [R_W-1:0] push_data,
  output logic           full,
  input  logic           pop,
  output logic           empty,
  output logic [R_W-1:0] dout
);

  localparam int PW = ptr_w(DEPTH);

  logic [R_W-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]    mem_cnt_reg;
  logic           out_valid_reg;
  logic [R_W-1:0] out_data_reg;

  logic pop_eff, load, mem_nonempty, push_ok, direct, mem_wr, mem_rd;

  // Occupancy counts the output register, so full means DEPTH results held in total.
  assign full         = (mem_cnt_reg + (PW+1)'(out_valid_reg)) == (PW+1)'(DEPTH);
  assign empty        = !out_valid_reg;
  assign dout         = out_data_reg;
  assign pop_eff      = pop && out_valid_reg;
  assign load         = !out_valid_reg || pop_eff;
  assign mem_nonempty = (mem_cnt_reg != '0);
  assign push_ok      = push && (!full || pop_eff);
  assign direct       = push_ok && load && !mem_nonempty;
  assign mem_wr       = push_ok && !direct;
  assign mem_rd       = load && mem_nonempty;

  always_ff @(posedge clock) begin
    if (mem_wr) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      mem_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      if (mem_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (mem_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      mem_cnt_reg <= mem_cnt_reg + (PW+1)'(mem_wr) - (PW+1)'(mem_rd);
      if (mem_rd) begin
        out_data_reg  <= mem[rd_ptr_reg];
        out_valid_reg <= 1'b1;
      end else if (direct) begin
        out_data_reg  <= push_data;
        out_valid_reg <= 1'b1;
      end else if (pop_eff) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hls_call_driver.sv
// Caller-side initiator: issues credit-limited calls on start/busy and
// buffers component results for a downstream valid/ready consumer.
module hls_call_driver
  import hls_call_pkg::*;
#(
  parameter int A_W       = DEF_A_W,
  parameter int N_W       = DEF_N_W,
  parameter int R_W       = DEF_R_W,
  parameter int RES_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [A_W-1:0]   req_a,
  input  logic [N_W-1:0]   req_n,
  output logic             start,
  input  logic             busy,
  output logic [A_W-1:0]   a,
  output logic [N_W-1:0]   n,
  input  logic             done,
  output logic             stall,
  input  logic [R_W-1:0]   returndata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [R_W-1:0]   rsp_data,
  output logic [CNT_W-1:0] calls_issued,
  output logic [CNT_W-1:0] results_done,
  output logic             err_unexpected_done
);

  localparam int CW = ptr_w(RES_DEPTH) + 1;

  issue_state_e   state_reg, state_next;
  logic [A_W-1:0] a_reg, a_next;
  logic [N_W-1:0] n_reg, n_next;
  logic [CW-1:0]  reserved_reg, outstanding_reg;
  logic [CNT_W-1:0] calls_reg, results_reg;
  logic           err_reg;

  logic can_accept, req_accept, call_accept, ret_accept, unexpected, pop;
  logic fifo_full, fifo_empty;

  assign can_accept = (reserved_reg < CW'(RES_DEPTH));

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    n_next      = n_reg;
    req_ready   = 1'b0;
    start       = 1'b0;
    req_accept  = 1'b0;
    call_accept = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = can_accept;
        if (req_valid && can_accept) begin
          req_accept = 1'b1;
          a_next     = req_a;
          n_next     = req_n;
          state_next = CALL;
        end
      end
      CALL: begin
        start = 1'b1;
        if (!busy) begin
          call_accept = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A call accepted this cycle already counts as outstanding for a coincident done.
  assign ret_accept = done && !stall && ((outstanding_reg != '0) || call_accept);
  assign unexpected = done && (outstanding_reg == '0) && !call_accept;
  assign pop        = rsp_valid && rsp_ready;
  // Credits keep FIFO occupancy plus outstanding calls within RES_DEPTH, so this stays low.
  assign stall      = fifo_full && (outstanding_reg != '0);
  assign rsp_valid  = !fifo_empty;

  assign a                   = a_reg;
  assign n                   = n_reg;
  assign calls_issued        = calls_reg;
  assign results_done        = results_reg;
  assign err_unexpected_done = err_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= IDLE;
      a_reg           <= '0;
      n_reg           <= '0;
      reserved_reg    <= '0;
      outstanding_reg <= '0;
      calls_reg       <= '0;
      results_reg     <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      n_reg     <= n_next;
      reserved_reg    <= reserved_reg + CW'(req_accept) - CW'(pop);
      outstanding_reg <= outstanding_reg + CW'(call_accept) - CW'(ret_accept);
      if (call_accept) calls_reg   <= calls_reg + 1'b1;
      if (pop)         results_reg <= results_reg + 1'b1;
      if (unexpected)  err_reg     <= 1'b1;
    end
  end

  hls_call_result_fifo #(
    .R_W   (R_W),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (ret_accept),
    .push_data (returndata),
    .full      (fifo_full),
    .pop       (rsp_ready),
    .empty     (fifo_empty),
    .dout      (rsp_data)
  );

endmodule

// File: tb/tb_hls_call_driver.sv
// Directed bench for hls_call_driver with a result scoreboard.
module tb_hls_call_driver;

  localparam int A_W = 64, N_W = 32, R_W = 32, RES_DEPTH = 4, CNT_W = 16;

  logic             clock = 1'b0;
  logic             resetn;
  logic             req_valid, req_ready;
  logic [A_W-1:0]   req_a;
  logic [N_W-1:0]   req_n;
  logic             start, busy;
  logic [A_W-1:0]   a;
  logic [N_W-1:0]   n;
  logic             done, stall;
  logic [R_W-1:0]   returndata;
  logic             rsp_valid, rsp_ready;
  logic [R_W-1:0]   rsp_data;
  logic [CNT_W-1:0] calls_issued, results_done;
  logic             err_unexpected_done;

  int tests = 0;
  int fails = 0;
  logic [R_W-1:0] sb[$];

  hls_call_driver #(
    .A_W(A_W), .N_W(N_W), .R_W(R_W), .RES_DEPTH(RES_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_n(req_n),
    .start(start), .busy(busy), .a(a), .n(n),
    .done(done), .stall(stall), .returndata(returndata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .calls_issued(calls_issued), .results_done(results_done),
    .err_unexpected_done(err_unexpected_done)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake on the result port must match the oldest expected result.
  always @(negedge clock) begin
    if (resetn && rsp_valid && rsp_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $error("FAIL rsp_extra observed=%0h expected=none", rsp_data);
      end else begin
        logic [R_W-1:0] e;
        e = sb.pop_front();
        assert (rsp_data === e) else begin
          fails++;
          $error("FAIL rsp_order observed=%0h expected=%0h", rsp_data, e);
        end
        $display("[TB] rsp %0h (expected %0h)", rsp_data, e);
      end
    end
  end

  task automatic issue_call(input logic [A_W-1:0] va, input logic [N_W-1:0] vn);
    int k;
    req_a = va; req_n = vn; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin tick(); k++; end
    chk("issue_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    tick();
    $display("[TB] call a=%0h n=%0d", va, vn);
  endtask

  task automatic ret_result(input logic [R_W-1:0] v);
    done = 1'b1; returndata = v;
    sb.push_back(v);
    chk("stall_lo", stall, 0);
    tick();
    done = 1'b0;
    $display("[TB] return %0h", v);
  endtask

  task automatic run_single();
    busy = 1'b0; rsp_ready = 1'b1;
    req_a = 64'h1000; req_n = 32'd5; req_valid = 1'b1;
    chk("s1_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("s1_start_hi", start, 1);
    chk("s1_a", a, 64'h1000);
    chk("s1_n", n, 5);
    chk("s1_ready_lo", req_ready, 0);
    tick();
    chk("s1_start_lo", start, 0);
    chk("s1_calls", calls_issued, 1);
    repeat (8) tick();
    done = 1'b1; returndata = 32'h2A; sb.push_back(32'h2A);
    tick();
    done = 1'b0;
    chk("s1_rsp_valid", rsp_valid, 1);
    chk("s1_rsp_data", rsp_data, 32'h2A);
    tick();
    chk("s1_rsp_valid_lo", rsp_valid, 0);
    chk("s1_results", results_done, 1);
    $display("[TB] single call complete");
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_a = '0; req_n = '0;
    busy = 1'b0; done = 1'b0; returndata = '0; rsp_ready = 1'b1;
    repeat (2) tick();
    chk("rst_start", start, 0);
    chk("rst_a", a, 0);
    chk("rst_n", n, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_calls", calls_issued, 0);
    chk("rst_results", results_done, 0);
    chk("rst_err", err_unexpected_done, 0);
    resetn = 1'b1;
    tick();

    run_single();

    // Busy backpressure: 7 stalled cycles, accepted on the 8th.
    busy = 1'b1; req_a = 64'hABCD; req_n = 32'd9; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("bp_start", start, 1);
      chk("bp_a", a, 64'hABCD);
      chk("bp_n", n, 9);
      chk("bp_ready", req_ready, 0);
      tick();
    end
    chk("bp_start_last", start, 1);
    busy = 1'b0;
    tick();
    chk("bp_start_lo", start, 0);
    chk("bp_calls", calls_issued, 2);
    ret_result(32'h55);
    repeat (2) tick();
    chk("bp_results", results_done, 2);
    $display("[TB] busy backpressure complete");

    // Credit exhaustion.
    rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) issue_call(64'h2000 + 64'(i), 32'(i));
    chk("cr_ready_lo", req_ready, 0);
    for (int i = 1; i <= 4; i++) ret_result(32'(i));
    chk("cr_rsp_valid", rsp_valid, 1);
    chk("cr_stall", stall, 0);
    req_valid = 1'b1; req_a = 64'h5555; req_n = 32'd5;
    for (int i = 0; i < 3; i++) begin
      chk("cr_5th_ready", req_ready, 0);
      chk("cr_5th_start", start, 0);
      tick();
    end
    req_valid = 1'b0;
    chk("cr_calls", calls_issued, 6);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("cr_ready_back", req_ready, 1);
    chk("cr_results", results_done, 3);
    $display("[TB] credit exhaustion complete");

    // Ordering with a push coinciding with a pop.
    issue_call(64'h3000, 32'd9);
    done = 1'b1; returndata = 32'd5; sb.push_back(32'd5); rsp_ready = 1'b1;
    chk("ord_valid", rsp_valid, 1);
    tick();
    done = 1'b0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      rsp_ready = i[0];
      tick();
    end
    chk("ord_drained", 64'(sb.size()), 0);
    chk("ord_valid_lo", rsp_valid, 0);
    chk("ord_results", results_done, 7);
    chk("ord_calls", calls_issued, 7);
    $display("[TB] ordering complete");

    // Unexpected done.
    rsp_ready = 1'b1;
    chk("err_pre", err_unexpected_done, 0);
    done = 1'b1; returndata = 32'hDEAD;
    tick();
    done = 1'b0;
    chk("err_set", err_unexpected_done, 1);
    chk("err_rsp_valid", rsp_valid, 0);
    repeat (3) tick();
    chk("err_sticky", err_unexpected_done, 1);
    chk("err_results", results_done, 7);
    $display("[TB] protocol error complete");

    // Reset mid-flight: 2 outstanding, 1 buffered, one more call stalled on busy.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue_call(64'h4000 + 64'(i), 32'(i));
    ret_result(32'h77);
    chk("mr_rsp_valid", rsp_valid, 1);
    busy = 1'b1; req_a = 64'h4444; req_n = 32'd4; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("mr_start_pre", start, 1);
    #2 resetn = 1'b0;
    #1;
    sb.delete();
    chk("mr_start", start, 0);
    chk("mr_a", a, 0);
    chk("mr_n", n, 0);
    chk("mr_rsp_valid_lo", rsp_valid, 0);
    chk("mr_rsp_data", rsp_data, 0);
    chk("mr_calls", calls_issued, 0);
    chk("mr_results", results_done, 0);
    chk("mr_err", err_unexpected_done, 0);
    busy = 1'b0;
    repeat (2) tick();
    chk("mr_start_held", start, 0);
    resetn = 1'b1;
    tick();
    run_single();
    chk("mr_err_after", err_unexpected_done, 0);
    $display("[TB] reset mid-flight complete");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
